mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_controller_if.sv | 49 ++++
 rtl/mem_controller.sv | 123 ++++++++++++
 tb/tb_mem_controller.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_if.sv
// Cache-side and host-side bus bundle for the memory controller.
// The slave modport is the controller; the master modport is whatever
// sits on the other side (caches plus host memory, or a bench).
interface mem_controller_if;
  // iCache fetch miss
  logic         cacheMissFetch;
  logic [31:0]  instrAddr;
  logic         mcInstrValid;
  logic [511:0] mcInstrIn;
  // dCache data miss
  logic         cacheMissMemory;
  logic [31:0]  mcDataAddr;
  logic         mcDataValid;
  logic [511:0] mcDataIn;
  // dCache dirty-line evict
  logic         dCacheEvict;
  logic [31:0]  evictAddr;
  logic [511:0] dCacheOut;
  logic         evictDone;
  // host timeout error
  logic         mcErr;
  // host memory port
  logic         hostReq;
  logic         hostWe;
  logic [31:0]  hostAddr;
  logic [511:0] hostWrData;
  logic         hostReady;
  logic         hostRdValid;
  logic [511:0] hostRdData;
  logic         hostWrDone;

  modport slave (
    input  cacheMissFetch, instrAddr,
    input  cacheMissMemory, mcDataAddr,
    input  dCacheEvict, evictAddr, dCacheOut,
    output mcInstrValid, mcInstrIn, mcDataValid, mcDataIn, evictDone, mcErr,
    output hostReq, hostWe, hostAddr, hostWrData,
    input  hostReady, hostRdValid, hostRdData, hostWrDone
  );

  modport master (
    output cacheMissFetch, instrAddr,
    output cacheMissMemory, mcDataAddr,
    output dCacheEvict, evictAddr, dCacheOut,
    input  mcInstrValid, mcInstrIn, mcDataValid, mcDataIn, evictDone, mcErr,
    input  hostReq, hostWe, hostAddr, hostWrData,
    output hostReady, hostRdValid, hostRdData, hostWrDone
  );
endinterface

// File: rtl/mem_controller.sv
// Single-outstanding memory controller: arbitrates dCache evicts, dCache
// fills and iCache fills onto one host line port, with a per-transaction
// wait timeout. All outputs are registered.
module mem_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  mem_controller_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_EVICT, OP_DFILL, OP_IFILL} op_t;

  // Counter value on the last permitted cycle; hitting it without progress aborts.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  op_t        op;
  logic [7:0] wait_cnt;

  logic rsp_hit;
  logic cnt_expired;

  // Only the strobe matching the latched op can complete it; the other is ignored.
  assign rsp_hit     = (op == OP_EVICT) ? bus.hostWrDone : bus.hostRdValid;
  assign cnt_expired = (wait_cnt == CNT_LAST);

  // Main FSM: arbitration, host handshake, completion pulses and timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      op               <= OP_EVICT;
      wait_cnt         <= '0;
      bus.mcInstrValid <= 1'b0;
      bus.mcInstrIn    <= '0;
      bus.mcDataValid  <= 1'b0;
      bus.mcDataIn     <= '0;
      bus.evictDone    <= 1'b0;
      bus.mcErr        <= 1'b0;
      bus.hostReq      <= 1'b0;
      bus.hostWe       <= 1'b0;
      bus.hostAddr     <= '0;
      bus.hostWrData   <= '0;
    end else begin
      // Pulses last one cycle unless re-asserted below.
      bus.mcInstrValid <= 1'b0;
      bus.mcDataValid  <= 1'b0;
      bus.evictDone    <= 1'b0;
      bus.mcErr        <= 1'b0;
      case (state)
        S_IDLE: begin
          // Evict wins so a dirty line is written before its slot is refilled.
          if (bus.dCacheEvict) begin
            op             <= OP_EVICT;
            bus.hostAddr   <= {bus.evictAddr[31:6], 6'b0};
            bus.hostWrData <= bus.dCacheOut;
            bus.hostWe     <= 1'b1;
            bus.hostReq    <= 1'b1;
            wait_cnt       <= '0;
            state          <= S_REQ;
          end else if (bus.cacheMissMemory) begin
            op           <= OP_DFILL;
            bus.hostAddr <= {bus.mcDataAddr[31:6], 6'b0};
            bus.hostWe   <= 1'b0;
            bus.hostReq  <= 1'b1;
            wait_cnt     <= '0;
            state        <= S_REQ;
          end else if (bus.cacheMissFetch) begin
            op           <= OP_IFILL;
            bus.hostAddr <= {bus.instrAddr[31:6], 6'b0};
            bus.hostWe   <= 1'b0;
            bus.hostReq  <= 1'b1;
            wait_cnt     <= '0;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          // Request fields are untouched here, so they stay stable under backpressure.
          if (bus.hostReady) begin
            bus.hostReq <= 1'b0;
            bus.hostWe  <= 1'b0;
            wait_cnt    <= '0;
            state       <= S_WAIT;
          end else if (cnt_expired) begin
            bus.hostReq <= 1'b0;
            bus.hostWe  <= 1'b0;
            bus.mcErr   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (rsp_hit) begin
            state <= S_DONE;
            case (op)
              OP_EVICT: bus.evictDone <= 1'b1;
              OP_DFILL: begin
                bus.mcDataIn    <= bus.hostRdData;
                bus.mcDataValid <= 1'b1;
              end
              default: begin
                bus.mcInstrIn    <= bus.hostRdData;
                bus.mcInstrValid <= 1'b1;
              end
            endcase
          end else if (cnt_expired) begin
            bus.mcErr <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          // Requester drops its level during this cycle; no arbitration here.
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: expected host transactions and
// completion pulses are queued when stimulus is raised and popped as the
// DUT produces them. A second instance with TIMEOUT=4 covers the abort path.
module tb_mem_controller;

  localparam int K_EVICT = 0;
  localparam int K_DFILL = 1;
  localparam int K_IFILL = 2;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [511:0] wdata;
    logic [511:0] rdata;
  } host_t;

  typedef struct {
    int           kind;
    logic [511:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_controller_if bus();
  mem_controller_if bus_to();

  mem_controller u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_controller #(.TIMEOUT(4)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to.slave)
  );

  always #5 clk = ~clk;

  host_t exp_host[$];
  ev_t   exp_ev[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ev_cyc = 0;
  int rsp_delay = 0;
  int stall_left = 0;
  int stall_seen = 0;
  bit spurious = 1'b0;
  bit pend = 1'b0;
  bit pend_we = 1'b0;
  logic [511:0] pend_data = '0;
  int wait_left = 0;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push_host(input logic we, input logic [31:0] addr,
                           input logic [511:0] wdata, input logic [511:0] rdata);
    host_t h;
    h.we = we; h.addr = addr; h.wdata = wdata; h.rdata = rdata;
    exp_host.push_back(h);
  endtask

  task automatic push_ev(input int kind, input logic [511:0] data);
    ev_t e;
    e.kind = kind; e.data = data;
    exp_ev.push_back(e);
  endtask

  task automatic obs_ev(input int kind, input logic [511:0] data);
    ev_t e;
    last_ev_cyc = cyc;
    if (exp_ev.size() == 0) begin
      chk("unexpected_pulse", kind, 99);
    end else begin
      e = exp_ev.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_data", data, e.data);
    end
  endtask

  // One cycle of cache requesters plus host model, acting on the falling edge.
  task automatic step();
    host_t h;
    @(negedge clk);
    cyc++;
    if (bus.evictDone)    begin obs_ev(K_EVICT, '0);            bus.dCacheEvict = 1'b0;     end
    if (bus.mcDataValid)  begin obs_ev(K_DFILL, bus.mcDataIn);  bus.cacheMissMemory = 1'b0; end
    if (bus.mcInstrValid) begin obs_ev(K_IFILL, bus.mcInstrIn); bus.cacheMissFetch = 1'b0;  end
    if (bus.mcErr) chk("unexpected_err", 1, 0);
    bus.hostRdValid = 1'b0;
    bus.hostWrDone  = 1'b0;
    if (pend) begin
      if (wait_left == 0) begin
        if (pend_we) bus.hostWrDone = 1'b1;
        else begin bus.hostRdValid = 1'b1; bus.hostRdData = pend_data; end
        pend = 1'b0;
      end else begin
        // Wrong-type strobe one cycle early must not complete the op.
        if (spurious && wait_left == 1) begin
          if (pend_we) begin bus.hostRdValid = 1'b1; bus.hostRdData = ~pend_data; end
          else bus.hostWrDone = 1'b1;
        end
        wait_left--;
      end
    end
    if (bus.hostReq && stall_left > 0) begin
      bus.hostReady = 1'b0;
      stall_left--;
      stall_seen++;
      chk("stall_req", bus.hostReq, 1'b1);
      if (exp_host.size() != 0) chk("stall_addr", bus.hostAddr, exp_host[0].addr);
    end else begin
      bus.hostReady = 1'b1;
    end
    if (bus.hostReq && bus.hostReady) begin
      if (exp_host.size() == 0) begin
        chk("unexpected_req", 1, 0);
      end else begin
        h = exp_host.pop_front();
        chk("one_outstanding", pend, 1'b0);
        chk("host_we", bus.hostWe, h.we);
        chk("host_addr", bus.hostAddr, h.addr);
        if (h.we) chk("host_wdata", bus.hostWrData, h.wdata);
        pend = 1'b1; pend_we = h.we; pend_data = h.rdata; wait_left = rsp_delay;
      end
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_ev.size() != 0 || exp_host.size() != 0 || pend) && n < budget) begin
      step();
      n++;
    end
    if (exp_ev.size() != 0 || exp_host.size() != 0 || pend) begin
      chk("run_budget", 1, 0);
      exp_ev.delete(); exp_host.delete(); pend = 1'b0;
    end
  endtask

  initial begin
    logic [511:0] d_a5, d_b, d_c, d_w, d_x, d_y, d_z;
    int c0, err_at, dv_cnt, err_cnt;
    d_a5 = {64{8'hA5}};
    d_b  = {16{32'h1234_5678}};
    d_c  = {16{32'hC0DE_0001}};
    d_w  = {16{32'hDEAD_BEEF}};
    d_x  = {8{64'h0123_4567_89AB_CDEF}};
    d_y  = {16{32'h5555_AAAA}};
    d_z  = {16{32'h0F0F_7777}};

    bus.cacheMissFetch = 0; bus.instrAddr = '0; bus.cacheMissMemory = 0; bus.mcDataAddr = '0;
    bus.dCacheEvict = 0; bus.evictAddr = '0; bus.dCacheOut = '0;
    bus.hostReady = 1; bus.hostRdValid = 0; bus.hostRdData = '0; bus.hostWrDone = 0;
    bus_to.cacheMissFetch = 0; bus_to.instrAddr = '0; bus_to.cacheMissMemory = 0; bus_to.mcDataAddr = '0;
    bus_to.dCacheEvict = 0; bus_to.evictAddr = '0; bus_to.dCacheOut = '0;
    bus_to.hostReady = 1; bus_to.hostRdValid = 0; bus_to.hostRdData = '0; bus_to.hostWrDone = 0;

    // Reset state
    #12;
    chk("rst_req", bus.hostReq, 0);
    chk("rst_we", bus.hostWe, 0);
    chk("rst_addr", bus.hostAddr, 0);
    chk("rst_wdata", bus.hostWrData, 0);
    chk("rst_pulses", {bus.mcInstrValid, bus.mcDataValid, bus.evictDone, bus.mcErr}, 0);
    chk("rst_fill_lines", bus.mcDataIn | bus.mcInstrIn, 0);
    @(negedge clk);
    rst = 1'b1;

    // Fetch miss, unaligned address, response 2 cycles after accept
    rsp_delay = 2;
    bus.cacheMissFetch = 1; bus.instrAddr = 32'h0000_1047;
    push_host(0, 32'h0000_1040, '0, d_a5);
    push_ev(K_IFILL, d_a5);
    run(40);

    // Minimum latency: data fill with ready host and zero-wait response
    step();
    rsp_delay = 0;
    bus.cacheMissMemory = 1; bus.mcDataAddr = 32'h8000_00FF;
    c0 = cyc;
    push_host(0, 32'h8000_00C0, '0, d_b);
    push_ev(K_DFILL, d_b);
    run(40);
    chk("min_latency", last_ev_cyc - c0, 3);

    // Evict and data miss together, with wrong-type strobes injected
    step();
    rsp_delay = 2; spurious = 1'b1;
    bus.dCacheEvict = 1; bus.evictAddr = 32'h0000_0200; bus.dCacheOut = d_w;
    bus.cacheMissMemory = 1; bus.mcDataAddr = 32'h0000_0400;
    push_host(1, 32'h0000_0200, d_w, '0);
    push_host(0, 32'h0000_0400, '0, d_c);
    push_ev(K_EVICT, '0);
    push_ev(K_DFILL, d_c);
    run(60);
    spurious = 1'b0;
    chk("ifill_line_held", bus.mcInstrIn, d_a5);

    // Host backpressure: ready low for 5 cycles while requesting
    step();
    rsp_delay = 1; stall_left = 5; stall_seen = 0;
    bus.cacheMissMemory = 1; bus.mcDataAddr = 32'h0000_2010;
    push_host(0, 32'h0000_2000, '0, d_x);
    push_ev(K_DFILL, d_x);
    run(60);
    chk("stall_cycles", stall_seen, 5);

    // All three requests at once
    step();
    rsp_delay = 1;
    bus.dCacheEvict = 1; bus.evictAddr = 32'h0000_3F3F; bus.dCacheOut = d_y;
    bus.cacheMissMemory = 1; bus.mcDataAddr = 32'h0000_5005;
    bus.cacheMissFetch = 1; bus.instrAddr = 32'h0000_7FFF;
    push_host(1, 32'h0000_3F00, d_y, '0);
    push_host(0, 32'h0000_5000, '0, d_z);
    push_host(0, 32'h0000_7FC0, '0, d_b);
    push_ev(K_EVICT, '0);
    push_ev(K_DFILL, d_z);
    push_ev(K_IFILL, d_b);
    run(80);
    chk("dfill_line_held", bus.mcDataIn, d_z);

    // Timeout instance: host accepts but never responds
    @(negedge clk);
    bus_to.cacheMissMemory = 1; bus_to.mcDataAddr = 32'h0000_1234;
    err_at = -1; dv_cnt = 0; err_cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (bus_to.mcDataValid) dv_cnt++;
      if (bus_to.mcErr) begin
        err_cnt++;
        if (err_at < 0) err_at = i;
        bus_to.cacheMissMemory = 0;
      end
    end
    chk("to_err_cycle", err_at, 6);
    chk("to_err_count", err_cnt, 1);
    chk("to_no_fill", dv_cnt, 0);
    chk("to_idle", bus_to.hostReq, 0);

    // Reset while waiting on the host; late response must be ignored
    step();
    rsp_delay = 6;
    bus.cacheMissFetch = 1; bus.instrAddr = 32'h0000_0040;
    push_host(0, 32'h0000_0040, '0, d_c);
    for (int i = 0; i < 10 && !pend; i++) step();
    chk("rst_mid_accepted", pend, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_req", bus.hostReq, 0);
    chk("rst_mid_addr", bus.hostAddr, 0);
    chk("rst_mid_lines", bus.mcInstrIn | bus.mcDataIn, 0);
    pend = 1'b0;
    exp_host.delete();
    bus.cacheMissFetch = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.hostRdValid = 1'b1;
    bus.hostRdData = d_w;
    repeat (4) step();
    chk("rst_late_no_fill", bus.mcInstrValid, 0);
    chk("rst_late_idle", bus.hostReq, 0);
    chk("rst_late_line", bus.mcInstrIn, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
